// File: rtl/kuznechik_pkg.sv
// -----------------------------------------------------------------------------
// kuznechik_pkg
// Shared definitions for the Kuznechik (GOST R 34.12-2015) key schedule:
//   - controller state encoding
//   - schedule dimensions (ROUND_KEYS, FEISTEL_N, LINEAR_N)
//   - GF(2^8) multiply, linear-layer coefficients, R step, S-box layer
//   - 32 x 128 round-constant table C[1..32], present only when
//     KUZNECHIK_KEY_CONST_ROM_EN is defined (built at elaboration from the
//     same R step, so it cannot drift from the datapath definition)
// -----------------------------------------------------------------------------
package kuznechik_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_EMIT0 = 3'd1,
    ST_EMIT1 = 3'd2,
    ST_CONST = 3'd3,
    ST_XS    = 3'd4,
    ST_L     = 3'd5,
    ST_F     = 3'd6,
    ST_DONE  = 3'd7
  } state_e;

  localparam int ROUND_KEYS = 32'd10;
  localparam int FEISTEL_N  = 32'd8;
  localparam int LINEAR_N   = 32'd16;

  // x^8 + x^7 + x^6 + x + 1 with the x^8 term dropped
  localparam logic [7:0] GF_POLY_LO = 8'hC3;

  // Coefficient for byte a15 (most significant) first, a0 last
  localparam logic [7:0] L_COEF [16] = '{
    8'd148, 8'd32,  8'd133, 8'd16,  8'd194, 8'd192, 8'd1, 8'd251,
    8'd1,   8'd192, 8'd194, 8'd16,  8'd133, 8'd32,  8'd148, 8'd1
  };

  localparam logic [7:0] SBOX [256] = '{
    8'hFC, 8'hEE, 8'hDD, 8'h11, 8'hCF, 8'h6E, 8'h31, 8'h16, 8'hFB, 8'hC4, 8'hFA, 8'hDA, 8'h23, 8'hC5, 8'h04, 8'h4D,
    8'hE9, 8'h77, 8'hF0, 8'hDB, 8'h93, 8'h2E, 8'h99, 8'hBA, 8'h17, 8'h36, 8'hF1, 8'hBB, 8'h14, 8'hCD, 8'h5F, 8'hC1,
    8'hF9, 8'h18, 8'h65, 8'h5A, 8'hE2, 8'h5C, 8'hEF, 8'h21, 8'h81, 8'h1C, 8'h3C, 8'h42, 8'h8B, 8'h01, 8'h8E, 8'h4F,
    8'h05, 8'h84, 8'h02, 8'hAE, 8'hE3, 8'h6A, 8'h8F, 8'hA0, 8'h06, 8'h0B, 8'hED, 8'h98, 8'h7F, 8'hD4, 8'hD3, 8'h1F,
    8'hEB, 8'h34, 8'h2C, 8'h51, 8'hEA, 8'hC8, 8'h48, 8'hAB, 8'hF2, 8'h2A, 8'h68, 8'hA2, 8'hFD, 8'h3A, 8'hCE, 8'hCC,
    8'hB5, 8'h70, 8'h0E, 8'h56, 8'h08, 8'h0C, 8'h76, 8'h12, 8'hBF, 8'h72, 8'h13, 8'h47, 8'h9C, 8'hB7, 8'h5D, 8'h87,
    8'h15, 8'hA1, 8'h96, 8'h29, 8'h10, 8'h7B, 8'h9A, 8'hC7, 8'hF3, 8'h91, 8'h78, 8'h6F, 8'h9D, 8'h9E, 8'hB2, 8'hB1,
    8'h32, 8'h75, 8'h19, 8'h3D, 8'hFF, 8'h35, 8'h8A, 8'h7E, 8'h6D, 8'h54, 8'hC6, 8'h80, 8'hC3, 8'hBD, 8'h0D, 8'h57,
    8'hDF, 8'hF5, 8'h24, 8'hA9, 8'h3E, 8'hA8, 8'h43, 8'hC9, 8'hD7, 8'h79, 8'hD6, 8'hF6, 8'h7C, 8'h22, 8'hB9, 8'h03,
    8'hE0, 8'h0F, 8'hEC, 8'hDE, 8'h7A, 8'h94, 8'hB0, 8'hBC, 8'hDC, 8'hE8, 8'h28, 8'h50, 8'h4E, 8'h33, 8'h0A, 8'h4A,
    8'hA7, 8'h97, 8'h60, 8'h73, 8'h1E, 8'h00, 8'h62, 8'h44, 8'h1A, 8'hB8, 8'h38, 8'h82, 8'h64, 8'h9F, 8'h26, 8'h41,
    8'hAD, 8'h45, 8'h46, 8'h92, 8'h27, 8'h5E, 8'h55, 8'h2F, 8'h8C, 8'hA3, 8'hA5, 8'h7D, 8'h69, 8'hD5, 8'h95, 8'h3B,
    8'h07, 8'h58, 8'hB3, 8'h40, 8'h86, 8'hAC, 8'h1D, 8'hF7, 8'h30, 8'h37, 8'h6B, 8'hE4, 8'h88, 8'hD9, 8'hE7, 8'h89,
    8'hE1, 8'h1B, 8'h83, 8'h49, 8'h4C, 8'h3F, 8'hF8, 8'hFE, 8'h8D, 8'h53, 8'hAA, 8'h90, 8'hCA, 8'hD8, 8'h85, 8'h61,
    8'h20, 8'h71, 8'h67, 8'hA4, 8'h2D, 8'h2B, 8'h09, 8'h5B, 8'hCB, 8'h9B, 8'h25, 8'hD0, 8'hBE, 8'hE5, 8'h6C, 8'h52,
    8'h59, 8'hA6, 8'h74, 8'hD2, 8'hE6, 8'hF4, 8'hB4, 8'hC0, 8'hD1, 8'h66, 8'hAF, 8'hC2, 8'h39, 8'h4B, 8'h63, 8'hB6
  };

  // Shift-and-add multiply in GF(2^8)
  function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] p;
    logic [7:0] m;
    p = 8'h00;
    m = x;
    for (int k = 0; k < 8; k++) begin
      p = y[k] ? (p ^ m) : p;
      m = m[7] ? ({m[6:0], 1'b0} ^ GF_POLY_LO) : {m[6:0], 1'b0};
    end
    return p;
  endfunction

  // R step: linear combination becomes the new top byte, a0 falls off
  function automatic logic [127:0] r_step_f(input logic [127:0] x);
    logic [7:0] acc;
    acc = 8'h00;
    for (int k = 0; k < LINEAR_N; k++) begin
      acc = acc ^ gf_mul(L_COEF[LINEAR_N - 1 - k], x[8*k +: 8]);
    end
    return {acc, x[127:8]};
  endfunction

  // Bytewise S-box substitution
  function automatic logic [127:0] s_layer(input logic [127:0] x);
    logic [127:0] y;
    y = 128'd0;
    for (int k = 0; k < LINEAR_N; k++) begin
      y[8*k +: 8] = SBOX[x[8*k +: 8]];
    end
    return y;
  endfunction

`ifdef KUZNECHIK_KEY_CONST_ROM_EN
  // C[n] = L(vec128(n)); entry n-1 lives at bits [(n-1)*128 +: 128]
  function automatic logic [32*128-1:0] c_table_gen();
    logic [32*128-1:0] tab;
    logic [127:0]      v;
    tab = '0;
    for (int n = 1; n <= 32; n++) begin
      v = {120'd0, 8'(n)};
      for (int s = 0; s < LINEAR_N; s++) begin
        v = r_step_f(v);
      end
      tab[(n-1)*128 +: 128] = v;
    end
    return tab;
  endfunction

  localparam logic [32*128-1:0] C_TABLE = c_table_gen();
`endif

endpackage

// File: rtl/kuznechik_r_step.sv
// -----------------------------------------------------------------------------
// kuznechik_r_step
// Combinational single R step of the Kuznechik linear layer. One instance is
// time-shared by the round-constant (CONST) and linear (L) phases.
//   x   : 128-bit input block
//   r_x : R(x)
// -----------------------------------------------------------------------------
module kuznechik_r_step
  import kuznechik_pkg::*;
(
  input  logic [127:0] x,
  output logic [127:0] r_x
);

  // One byte-shift plus GF(2^8) linear combination
  always_comb begin
    r_x = r_step_f(x);
  end

endmodule

// File: rtl/kuznechik_key_expand.sv
// -----------------------------------------------------------------------------
// kuznechik_key_expand
// Iterative Kuznechik key schedule. Expands a 256-bit master key into ten
// 128-bit round keys written one per cycle to an external key store.
//
// Ports
//   clk_i       : clock, rising edge
//   rst_i       : asynchronous active-high reset
//   start_i     : begin expansion of key_i (only honoured in IDLE)
//   key_i       : master key, [255:128] = K1, [127:0] = K2
//   busy_o      : high whenever not IDLE
//   done_o      : one-cycle pulse after the tenth key write
//   key_we_o    : round-key write strobe
//   key_addr_o  : round-key index 0..9
//   key_data_o  : round-key value (zero when key_we_o is low)
//
// Build option
//   KUZNECHIK_KEY_CONST_ROM_EN defined  : round constants read from a table,
//                                         18 cycles per Feistel iteration
//   KUZNECHIK_KEY_CONST_ROM_EN undefined: each constant is computed on the
//                                         fly in CONST (16 R steps),
//                                         34 cycles per Feistel iteration
// -----------------------------------------------------------------------------
module kuznechik_key_expand
  import kuznechik_pkg::*;
(
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         start_i,
  input  logic [255:0] key_i,
  output logic         busy_o,
  output logic         done_o,
  output logic         key_we_o,
  output logic [3:0]   key_addr_o,
  output logic [127:0] key_data_o
);

  localparam logic [2:0] J_LAST = 3'((ROUND_KEYS / 32'd2) - 32'd1);
  localparam logic [2:0] I_LAST = 3'(FEISTEL_N - 32'd1);
  localparam logic [3:0] L_LAST = 4'(LINEAR_N - 32'd1);

`ifdef KUZNECHIK_KEY_CONST_ROM_EN
  localparam state_e ST_ROUND_ENTRY = ST_XS;
`else
  localparam state_e ST_ROUND_ENTRY = ST_CONST;

  // vec128(8j+i+1): seed of the on-the-fly constant computation
  function automatic logic [127:0] const_seed(input logic [2:0] j, input logic [2:0] i);
    return {122'd0, ({j, i} + 6'd1)};
  endfunction
`endif

  state_e         state_r;
  state_e         state_nxt_s;
  logic [127:0]   a_r, b_r, t_r;
  logic [127:0]   a_nxt_s, b_nxt_s, t_nxt_s;
  logic [2:0]     j_r, i_r;
  logic [2:0]     j_nxt_s, i_nxt_s;
  logic [3:0]     l_r, l_nxt_s;
  logic [127:0]   r_out_s;
  logic [127:0]   rc_s;

  logic           busy_r, done_r, we_r;
  logic [3:0]     addr_r;
  logic [127:0]   data_r;
  logic           busy_nxt_s, done_nxt_s, we_nxt_s;
  logic [3:0]     addr_nxt_s;
  logic [127:0]   data_nxt_s;

  kuznechik_r_step u_r_step (
    .x   (t_r),
    .r_x (r_out_s)
  );

`ifdef KUZNECHIK_KEY_CONST_ROM_EN
  // j never exceeds 3 while in XS, so two bits of j address the 32 entries
  assign rc_s = C_TABLE[{j_r[1:0], i_r, 7'd0} +: 128];
`else
  // CONST has just left C[8j+i+1] in t
  assign rc_s = t_r;
`endif

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE:  state_nxt_s = start_i ? ST_EMIT0 : ST_IDLE;
      ST_EMIT0: state_nxt_s = ST_EMIT1;
      ST_EMIT1: state_nxt_s = (j_r == J_LAST) ? ST_DONE : ST_ROUND_ENTRY;
      ST_CONST: state_nxt_s = (l_r == L_LAST) ? ST_XS : ST_CONST;
      ST_XS:    state_nxt_s = ST_L;
      ST_L:     state_nxt_s = (l_r == L_LAST) ? ST_F : ST_L;
      ST_F:     state_nxt_s = (i_r == I_LAST) ? ST_EMIT0 : ST_ROUND_ENTRY;
      ST_DONE:  state_nxt_s = ST_IDLE;
      default:  state_nxt_s = ST_IDLE;
    endcase
  end

  // Datapath and counter next values
  always_comb begin
    a_nxt_s = a_r;
    b_nxt_s = b_r;
    t_nxt_s = t_r;
    j_nxt_s = j_r;
    i_nxt_s = i_r;
    l_nxt_s = 4'd0;
    case (state_r)
      ST_IDLE: begin
        if (start_i) begin
          a_nxt_s = key_i[255:128];
          b_nxt_s = key_i[127:0];
          j_nxt_s = 3'd0;
          i_nxt_s = 3'd0;
        end else begin
          a_nxt_s = a_r;
          b_nxt_s = b_r;
        end
      end
      ST_EMIT1: begin
        i_nxt_s = 3'd0;
`ifndef KUZNECHIK_KEY_CONST_ROM_EN
        t_nxt_s = const_seed(j_r, 3'd0);
`endif
      end
      ST_CONST, ST_L: begin
        t_nxt_s = r_out_s;
        l_nxt_s = (l_r == L_LAST) ? 4'd0 : (l_r + 4'd1);
      end
      ST_XS: begin
        t_nxt_s = s_layer(a_r ^ rc_s);
      end
      ST_F: begin
        a_nxt_s = t_r ^ b_r;
        b_nxt_s = a_r;
        if (i_r == I_LAST) begin
          j_nxt_s = (j_r == J_LAST) ? j_r : (j_r + 3'd1);
        end else begin
          i_nxt_s = i_r + 3'd1;
`ifndef KUZNECHIK_KEY_CONST_ROM_EN
          t_nxt_s = const_seed(j_r, i_r + 3'd1);
`endif
        end
      end
      default: begin
        t_nxt_s = t_r;
      end
    endcase
  end

  // Outputs decoded from the next state so they can be registered
  // without adding a cycle of latency
  always_comb begin
    busy_nxt_s = (state_nxt_s != ST_IDLE);
    done_nxt_s = (state_nxt_s == ST_DONE);
    we_nxt_s   = 1'b0;
    addr_nxt_s = 4'd0;
    data_nxt_s = 128'd0;
    case (state_nxt_s)
      ST_EMIT0: begin
        we_nxt_s   = 1'b1;
        addr_nxt_s = {j_nxt_s, 1'b0};
        data_nxt_s = a_nxt_s;
      end
      ST_EMIT1: begin
        we_nxt_s   = 1'b1;
        addr_nxt_s = {j_nxt_s, 1'b1};
        data_nxt_s = b_nxt_s;
      end
      default: begin
        we_nxt_s = 1'b0;
      end
    endcase
  end

  // Datapath, counter and output registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      a_r    <= 128'd0;
      b_r    <= 128'd0;
      t_r    <= 128'd0;
      j_r    <= 3'd0;
      i_r    <= 3'd0;
      l_r    <= 4'd0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      we_r   <= 1'b0;
      addr_r <= 4'd0;
      data_r <= 128'd0;
    end else begin
      a_r    <= a_nxt_s;
      b_r    <= b_nxt_s;
      t_r    <= t_nxt_s;
      j_r    <= j_nxt_s;
      i_r    <= i_nxt_s;
      l_r    <= l_nxt_s;
      busy_r <= busy_nxt_s;
      done_r <= done_nxt_s;
      we_r   <= we_nxt_s;
      addr_r <= addr_nxt_s;
      data_r <= data_nxt_s;
    end
  end

  assign busy_o     = busy_r;
  assign done_o     = done_r;
  assign key_we_o   = we_r;
  assign key_addr_o = addr_r;
  assign key_data_o = data_r;

endmodule

// File: tb/tb_kuznechik_key_expand.sv
// -----------------------------------------------------------------------------
// tb_kuznechik_key_expand
// Directed bench for kuznechik_key_expand using the GOST R 34.12-2015 key.
// Cycle numbers are relative to the clock edge that samples start_i (cycle 0).
// Honours KUZNECHIK_KEY_CONST_ROM_EN for the expected latency.
// -----------------------------------------------------------------------------
module tb_kuznechik_key_expand;

`ifdef KUZNECHIK_KEY_CONST_ROM_EN
  localparam int PAIR     = 146;
  localparam int DONE_LAT = 587;
  localparam int PRE_RST  = 4;
`else
  localparam int PAIR     = 274;
  localparam int DONE_LAT = 1099;
  localparam int PRE_RST  = 2;
`endif

  localparam logic [255:0] KEY = 256'h8899aabbccddeeff0011223344556677fedcba98765432100123456789abcdef;
  localparam logic [127:0] RK0 = 128'h8899aabbccddeeff0011223344556677;
  localparam logic [127:0] RK1 = 128'hfedcba98765432100123456789abcdef;
  localparam logic [127:0] RK2 = 128'hdb31485315694343228d6aef8cc78c44;
  localparam logic [127:0] RK3 = 128'h3d4553d8e9cfec6815ebadc40a9ffd04;
  localparam logic [127:0] RK9 = 128'h72e9dd7416bcf45b755dbaa88e4a4043;
  localparam logic [127:0] C1  = 128'h6ea276726c487ab85d27bd10dd849401;

  logic         clk_i;
  logic         rst_i;
  logic         start_i;
  logic [255:0] key_i;
  logic         busy_o;
  logic         done_o;
  logic         key_we_o;
  logic [3:0]   key_addr_o;
  logic [127:0] key_data_o;

  int checks   = 0;
  int failures = 0;

  int           cyc_cnt = 0;
  int           wr_n    = 0;
  int           wr_cyc  [64];
  logic [3:0]   wr_addr [64];
  logic [127:0] wr_data [64];
  int           done_n   = 0;
  int           done_cyc = 0;

  int t0, base, prev, nwr;

  kuznechik_key_expand dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .start_i    (start_i),
    .key_i      (key_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .key_we_o   (key_we_o),
    .key_addr_o (key_addr_o),
    .key_data_o (key_data_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  always @(posedge clk_i) cyc_cnt <= cyc_cnt + 1;

  // Log every write and done pulse, sampled mid-cycle
  always @(negedge clk_i) begin
    if (!rst_i && key_we_o) begin
      if (wr_n < 64) begin
        wr_cyc[wr_n]  <= cyc_cnt;
        wr_addr[wr_n] <= key_addr_o;
        wr_data[wr_n] <= key_data_o;
      end
      wr_n <= wr_n + 1;
    end
    if (!rst_i && done_o) begin
      done_n   <= done_n + 1;
      done_cyc <= cyc_cnt;
    end
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        failures++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
  endtask

  // Bounded wait for the next done pulse; returns in the DONE cycle
  task automatic wait_done(input int start_cyc, input string tag);
    prev = done_n;
    for (int n = 0; n < 3000 && done_n == prev; n++) begin
      @(negedge clk_i);
      #1;
    end
    chk({tag, "_done_seen"}, done_n - prev, 1);
    chk({tag, "_done_cyc"}, done_cyc - start_cyc, DONE_LAT);
  endtask

  task automatic check_run(input int wbase, input int start_cyc, input string tag);
    chk({tag, "_nwr"}, wr_n - wbase, 10);
    for (int p = 0; p < 10; p++) begin
      chk($sformatf("%s_addr%0d", tag, p), wr_addr[wbase + p], p);
      chk($sformatf("%s_cyc%0d", tag, p), wr_cyc[wbase + p] - start_cyc, 1 + (p % 2) + (p / 2) * PAIR);
    end
  endtask

  initial begin
    rst_i   = 1'b1;
    start_i = 1'b0;
    key_i   = 256'd0;
    repeat (3) @(negedge clk_i);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_we",   key_we_o, 0);
    chk("rst_addr", key_addr_o, 0);
    chk("rst_data", key_data_o, 0);
    rst_i = 1'b0;
    repeat (2) @(negedge clk_i);

    // Run A: start held high for the whole expansion
    key_i = KEY; start_i = 1'b1; t0 = cyc_cnt; base = wr_n;
    repeat (19) @(negedge clk_i);
    #1;
    chk("a_busy_mid", busy_o, 1);
`ifndef KUZNECHIK_KEY_CONST_ROM_EN
    chk("a_c1_internal", dut.t_r, C1);
`endif
    wait_done(t0, "a");
    start_i = 1'b0;
    check_run(base, t0, "a");
    chk("a_rk0", wr_data[base + 0], RK0);
    chk("a_rk1", wr_data[base + 1], RK1);
    chk("a_rk2", wr_data[base + 2], RK2);
    chk("a_rk3", wr_data[base + 3], RK3);
    chk("a_rk9", wr_data[base + 9], RK9);
    repeat (5) @(negedge clk_i);
    #1;
    chk("a_idle_busy", busy_o, 0);
    chk("a_no_rerun", wr_n - base, 10);

    // Run B: one-cycle start, then a second start during DONE/IDLE
    @(negedge clk_i);
    start_i = 1'b1; t0 = cyc_cnt; base = wr_n;
    @(negedge clk_i);
    start_i = 1'b0;
    wait_done(t0, "b1");
    chk("b1_nwr", wr_n - base, 10);
    start_i = 1'b1;
    @(negedge clk_i);
    t0 = cyc_cnt; base = wr_n;
    #1;
    chk("b_idle_between", busy_o, 0);
    @(negedge clk_i);
    start_i = 1'b0;
    #1;
    chk("b2_busy", busy_o, 1);
    wait_done(t0, "b2");
    check_run(base, t0, "b2");
    chk("b2_rk9", wr_data[base + 9], RK9);

    // Run C: reset at cycle 200 aborts the expansion
    @(negedge clk_i);
    start_i = 1'b1; t0 = cyc_cnt; base = wr_n;
    @(negedge clk_i);
    start_i = 1'b0;
    repeat (199) @(negedge clk_i);
    rst_i = 1'b1;
    #1;
    chk("c_rst_busy", busy_o, 0);
    chk("c_rst_we",   key_we_o, 0);
    chk("c_rst_data", key_data_o, 0);
    chk("c_pre_rst_writes", wr_n - base, PRE_RST);
    nwr = wr_n;
    @(negedge clk_i);
    rst_i = 1'b0;
    repeat (400) @(negedge clk_i);
    #1;
    chk("c_no_writes_after", wr_n - nwr, 0);
    chk("c_busy_after", busy_o, 0);

    // Run D: full expansion after the abort
    @(negedge clk_i);
    start_i = 1'b1; t0 = cyc_cnt; base = wr_n;
    @(negedge clk_i);
    start_i = 1'b0;
    wait_done(t0, "d");
    check_run(base, t0, "d");
    chk("d_rk0", wr_data[base + 0], RK0);
    chk("d_rk2", wr_data[base + 2], RK2);
    chk("d_rk3", wr_data[base + 3], RK3);
    chk("d_rk9", wr_data[base + 9], RK9);

    repeat (2) @(negedge clk_i);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/kuznechik_key_expand.md
KUZNECHIK_KEY_EXPAND -- requirements
Module: kuznechik_key_expand

Interface
REQ-001 SHALL have ports: clk_i  input  1  sole clock; all logic on its rising edge.
REQ-002 SHALL have: rst_i  input  1  asynchronous, active-high reset.
REQ-003 SHALL have: start_i  input  1  request to expand key_i; accepted only in IDLE.
REQ-004 SHALL have: key_i  input  256  master key; [255:128] = K1, [127:0] = K2.
REQ-005 SHALL have: busy_o  output  1  high in every state except IDLE.
REQ-006 SHALL have: done_o  output  1  one-cycle pulse after all 10 round keys are written.
REQ-007 SHALL have: key_we_o  output  1  round-key write strobe to the cipher key store.
REQ-008 SHALL have: key_addr_o  output  4  round-key index 0..9 (K1..K10).
REQ-009 SHALL have: key_data_o  output  128  round-key value, valid while key_we_o is high.

Function
REQ-010 SHALL capture key_i into registers (a,b) = (K1,K2) in the cycle start_i is sampled high in IDLE; start_i at any other time SHALL be ignored.
REQ-011 SHALL implement states IDLE, EMIT0, EMIT1, CONST, XS, L, F, DONE.
REQ-012 EMIT0 SHALL write a to address 2j; EMIT1 SHALL write b to address 2j+1; j = pair counter 0..4.
REQ-013 After EMIT1: if j=4, go to DONE; else clear the iteration counter i (0..7) and go to CONST (macro absent) or XS (macro present).
REQ-014 XS (1 cycle): t = S(a XOR C[8j+i+1]), applied bytewise through the S-box.
REQ-015 L (16 cycles): apply one R step per cycle (byte-shift plus GF(2^8) linear combination, coefficients 148,32,133,16,194,192,1,251,1,192,194,16,133,32,148,1, polynomial x^8+x^7+x^6+x+1).
REQ-016 F (1 cycle): (a,b) <= (t XOR b, a); i increments. i=7 SHALL go to EMIT0 with j+1; otherwise to CONST/XS.
REQ-017 DONE (1 cycle): done_o=1, then IDLE.
REQ-018 key_we_o SHALL be high only in EMIT0/EMIT1, exactly 10 writes per expansion, addresses 0..9 ascending.
REQ-019 Latency with macro defined: start sampled at cycle 0, writes at cycles 1,2,147,148,...,585,586, done_o at cycle 587.
REQ-020 Latency without macro: 34 cycles per Feistel iteration; done_o at cycle 1099.
REQ-021 Counters SHALL NOT wrap: j saturates at 4, i at 7, and the L counter at 15 (one step per state).

Reset
REQ-022 rst_i high SHALL immediately force IDLE, clear a, b, t and all counters, and drive busy_o, done_o and key_we_o to 0, key_addr_o to 0 and key_data_o to 0.
REQ-023 Reset mid-expansion SHALL abort without further writes; the keys already written remain in the consumer's store and are stale.

Configuration
REQ-024 Macro KUZNECHIK_KEY_CONST_ROM_EN defined: C[1..32] SHALL come from a 32x128 constant table; path IDLE->EMIT->XS.
REQ-025 Macro absent: CONST state (16 cycles) SHALL compute C = L(vec128(8j+i+1)) using the L datapath, then go to XS; no constant table is instantiated.

Structure
REQ-026 Shared package kuznechik_pkg SHALL hold the state encoding, ROUND_KEYS=10, FEISTEL_N=8, LINEAR_N=16, the L coefficient list, the S-box, and the C table (the table under the macro only).
REQ-027 SHALL contain one sub-module, kuznechik_r_step: a combinational single R step, shared by the CONST and L phases.

Verification
REQ-028 GOST R 34.12-2015 key 8899aabbccddeeff0011223344556677fedcba98765432100123456789abcdef -> addr0=8899aabbccddeeff0011223344556677, addr1=fedcba98765432100123456789abcdef, addr2=db31485315694343228d6aef8cc78c44, addr3=3d4553d8e9cfec6815ebadc40a9ffd04, addr9=72e9dd7416bcf45b755dbaa88e4a4043.
REQ-029 Same key, both macro settings -> done_o at cycle 587 (macro defined) or 1099 (macro absent); exactly 10 key_we_o pulses.
REQ-030 Without macro, first CONST -> internal C[1]=6ea276726c487ab85d27bd10dd849401.
REQ-031 start_i held high for the whole expansion -> exactly one expansion; a second start_i in the cycle after done_o -> a new expansion.
REQ-032 rst_i pulse at cycle 200 -> busy_o=0 next edge, no further key_we_o; a subsequent start_i -> full correct expansion.
